// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the handshaked priority encoder.
package prio_enc_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_ge2(input logic [63:0] vec);
    return (vec & (vec - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/prio_encoder_hs_find.sv
// Combinational search: first set bit of req starting at index start, with wrap.
module prio_find #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [W-1:0]   off_s;
  logic [W:0]     sum_s;

  assign dbl_s = {req, req};
  assign rot_s = dbl_s[start +: N];
  assign found = |req;

  // Lowest set bit of the rotated view; scanning downward leaves the lowest hit.
  always_comb begin
    off_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? W'(i) : off_s;
    end
  end

  // Map the rotated offset back to an absolute index modulo N.
  always_comb begin
    sum_s = {1'b0, start} + {1'b0, off_s};
    if (sum_s >= (W+1)'(N)) begin
      idx = W'(sum_s - (W+1)'(N));
    end else begin
      idx = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/prio_encoder_hs.sv
// Registered N:log2(N) priority encoder with valid/ready handshake,
// fixed-priority or round-robin search.
module prio_encoder_hs
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = MODE_FIXED
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [N-1:0] in_req,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_none,
  output logic         out_multi
);

  logic         out_valid_r;
  logic [W-1:0] out_code_r;
  logic         out_none_r;
  logic         out_multi_r;
  logic [W-1:0] rr_ptr_r;

  logic         accept_s;
  logic         found_s;
  logic [W-1:0] idx_s;
  logic [W-1:0] start_s;

  assign in_ready = en && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;
  assign start_s  = (MODE == MODE_RR) ? rr_ptr_r : '0;

  prio_find #(.N(N), .W(W)) u_find (
    .req   (in_req),
    .start (start_s),
    .found (found_s),
    .idx   (idx_s)
  );

  // Result register, round-robin pointer and output-valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_code_r  <= '0;
      out_none_r  <= 1'b0;
      out_multi_r <= 1'b0;
      rr_ptr_r    <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_code_r  <= found_s ? idx_s : '0;
      out_none_r  <= !found_s;
      out_multi_r <= popcount_ge2(64'(in_req));
      if ((MODE == MODE_RR) && found_s) begin
        rr_ptr_r <= (idx_s == W'(N - 1)) ? '0 : idx_s + W'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_code  = out_code_r;
  assign out_none  = out_none_r;
  assign out_multi = out_multi_r;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Directed bench for prio_encoder_hs: three instances (N=8 fixed, N=8 RR, N=5 RR)
// share stimulus and are checked each cycle against an arithmetic model.
module tb_prio_encoder_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [7:0] in_req;
  logic       out_ready;

  logic       rdy0, vld0, none0, multi0;
  logic [2:0] code0;
  logic       rdy1, vld1, none1, multi1;
  logic [2:0] code1;
  logic       rdy2, vld2, none2, multi2;
  logic [2:0] code2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit v;
    int code;
    bit none;
    bit multi;
    int ptr;
  } st_t;

  st_t ms[3];

  always #5 clk = ~clk;

  prio_encoder_hs #(.N(8), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_req(in_req),
    .in_ready(rdy0), .out_valid(vld0), .out_ready(out_ready),
    .out_code(code0), .out_none(none0), .out_multi(multi0));

  prio_encoder_hs #(.N(8), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_req(in_req),
    .in_ready(rdy1), .out_valid(vld1), .out_ready(out_ready),
    .out_code(code1), .out_none(none1), .out_multi(multi1));

  prio_encoder_hs #(.N(5), .MODE(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_req(in_req[4:0]),
    .in_ready(rdy2), .out_valid(vld2), .out_ready(out_ready),
    .out_code(code2), .out_none(none2), .out_multi(multi2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural next state: scan n positions from the start index, modulo n.
  function automatic st_t model_step(st_t s, int n, int mode, bit e, bit iv,
                                     logic [7:0] rq, bit ordy);
    st_t r = s;
    bit [7:0] req = '0;
    int cnt = 0;
    int win = -1;
    int start;
    for (int j = 0; j < n; j++) begin
      req[j] = rq[j];
      cnt += int'(rq[j]);
    end
    start = mode ? s.ptr : 0;
    for (int k = 0; k < n; k++) begin
      if (win < 0 && req[(start + k) % n]) win = (start + k) % n;
    end
    if (iv && e && (!s.v || ordy)) begin
      r.v     = 1'b1;
      r.none  = (cnt == 0);
      r.multi = (cnt >= 2);
      r.code  = (win < 0) ? 0 : win;
      if (win >= 0 && mode == 1) r.ptr = (win + 1) % n;
    end else if (ordy) begin
      r.v = 1'b0;
    end
    return r;
  endfunction

  // Model state, reset asynchronously like the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) ms[i] <= '{1'b0, 0, 1'b0, 1'b0, 0};
    end else begin
      ms[0] <= model_step(ms[0], 8, 0, en, in_valid, in_req, out_ready);
      ms[1] <= model_step(ms[1], 8, 1, en, in_valid, in_req, out_ready);
      ms[2] <= model_step(ms[2], 5, 1, en, in_valid, in_req, out_ready);
    end
  end

  task automatic cmp(input int i, input logic rdy, input logic v, input logic [2:0] code,
                     input logic none, input logic multi);
    logic exp_rdy;
    exp_rdy = en && (!ms[i].v || out_ready);
    chk($sformatf("in_ready[%0d]", i), rdy, exp_rdy);
    chk($sformatf("out_valid[%0d]", i), v, ms[i].v);
    if (!rst_n || ms[i].v) begin
      chk($sformatf("out_code[%0d]", i), code, ms[i].code);
      chk($sformatf("out_none[%0d]", i), none, ms[i].none);
      chk($sformatf("out_multi[%0d]", i), multi, ms[i].multi);
    end
    if (i == 2 && v === 1'b1) chk("n5_code_range", code <= 3'd4, 1);
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    cmp(0, rdy0, vld0, code0, none0, multi0);
    cmp(1, rdy1, vld1, code1, none1, multi1);
    cmp(2, rdy2, vld2, code2, none2, multi2);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int rr8[6]  = '{0, 2, 7, 0, 2, 7};
    int rr5[6]  = '{0, 2, 0, 2, 0, 2};
    logic [7:0] tv_req[10] = '{8'h81, 8'h00, 8'h3C, 8'hFF, 8'h01, 8'h60, 8'h18, 8'h80, 8'h0F, 8'h42};
    bit tv_rdy[10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    bit tv_vld[10] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_req = 8'h00; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", vld0, 0);
    chk("rst_ready", rdy0, 0);
    chk("rst_code", code1, 0);
    rst_n = 1'b1; en = 1'b1;
    #1 chk("ready_follows_en", rdy0, 1);

    // One-hot vectors, full throughput
    in_valid = 1'b1; out_ready = 1'b1; in_req = 8'h10;
    tick();
    chk("t1_code_4", code0, 4);
    chk("t1_none", none0, 0);
    chk("t1_multi", multi0, 0);
    chk("t1_rr_code_4", code1, 4);
    chk("t1_n5_code_4", code2, 4);
    in_req = 8'h80;
    tick();
    chk("t1_code_7", code0, 7);
    chk("t1_rr_code_7", code1, 7);
    chk("t1_n5_none", none2, 1);

    // Multi-hot and all-zero
    in_req = 8'hA4;
    tick();
    chk("t2_code_2", code0, 2);
    chk("t2_multi", multi0, 1);
    in_req = 8'h00;
    tick();
    chk("t2_zero_code", code0, 0);
    chk("t2_zero_none", none0, 1);
    chk("t2_zero_valid", vld0, 1);

    // Round-robin rotation from a fresh pointer
    rst_n = 1'b0; #1; rst_n = 1'b1;
    in_req = 8'h85;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t3_rr8_%0d", k), code1, rr8[k]);
      chk($sformatf("t3_rr5_%0d", k), code2, rr5[k]);
    end

    // Stall holds the result, then replace with no bubble
    in_req = 8'h02;
    tick();
    chk("t4_code_1", code0, 1);
    out_ready = 1'b0; in_req = 8'h40;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stall_ready", rdy0, 0);
      chk("t4_stall_code", code0, 1);
      chk("t4_stall_valid", vld0, 1);
    end
    out_ready = 1'b1;
    #1 chk("t4_ready_back", rdy0, 1);
    tick();
    chk("t4_replace_code", code0, 6);
    chk("t4_replace_valid", vld0, 1);

    // Disable: drain only
    en = 1'b0; out_ready = 1'b0; in_req = 8'h08;
    tick();
    chk("t5_hold_valid", vld0, 1);
    chk("t5_hold_code", code0, 6);
    out_ready = 1'b1;
    #1 chk("t5_ready_low", rdy0, 0);
    tick();
    chk("t5_drained", vld0, 0);
    tick();
    chk("t5_no_accept", vld0, 0);
    en = 1'b1;
    #1 chk("t5_ready_en", rdy0, 1);
    tick();
    chk("t5_resume_valid", vld0, 1);
    chk("t5_resume_code", code0, 3);

    // Mixed traffic
    for (int k = 0; k < 10; k++) begin
      in_req = tv_req[k]; out_ready = tv_rdy[k]; in_valid = tv_vld[k];
      tick();
    end

    // Async reset mid-stream
    in_valid = 1'b1; out_ready = 1'b0; in_req = 8'h04;
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid2", vld2, 0);
    chk("t6_async_valid0", vld0, 0);
    tick();
    rst_n = 1'b1; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_req = 8'h1F;
    tick();
    chk("t6_n5_code_0", code2, 0);
    chk("t6_n5_multi", multi2, 1);
    chk("t6_rr8_code_0", code1, 0);
    in_valid = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
